// File: rtl/safe_pkg.sv
// safe_pkg: shared state encoding and password-length constants for the safe sequencer
package safe_pkg;
    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_IDLE    = 3'd1,
        S_ENTRY   = 3'd2,
        S_CHECK   = 3'd3,
        S_OPEN    = 3'd4,
        S_CHG_NEW = 3'd5,
        S_LOCKOUT = 3'd6
    } state_t;
    localparam logic [2:0] MIN_PW_LEN  = 3'd4;
    localparam logic [2:0] MAX_PW_LEN  = 3'd6;
    localparam logic [2:0] FACTORY_LEN = 3'd6;
endpackage

// File: rtl/safe_sequencer_if.sv
// safe_sequencer_if: keypad/datapath handshake between front end, comparator and sequencer
interface safe_sequencer_if;
    logic       is_on;
    logic       key_valid;
    logic       star_valid;
    logic       change_req;
    logic [2:0] input_length;
    logic       correct;
    logic       digit_accept;
    logic       clear_input;
    logic       parallel_load;
    logic [2:0] commit_length;
    logic       changing_password;
    logic       door_open;
    logic       alarm;
    logic [1:0] fail_count;
    logic [2:0] state;
    modport master (
        output is_on, key_valid, star_valid, change_req, input_length, correct,
        input  digit_accept, clear_input, parallel_load, commit_length,
               changing_password, door_open, alarm, fail_count, state
    );
    modport slave (
        input  is_on, key_valid, star_valid, change_req, input_length, correct,
        output digit_accept, clear_input, parallel_load, commit_length,
               changing_password, door_open, alarm, fail_count, state
    );
endinterface

// File: rtl/safe_timer.sv
// safe_timer: loadable down-counter that holds at zero
module safe_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign zero = (cnt_q == '0);
    always_comb cnt_d = load ? value : (zero ? cnt_q : cnt_q - 1'b1);
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/safe_sequencer.sv
// safe_sequencer: keypad safe control FSM: entry, check, door timing, password change and lockout
module safe_sequencer
    import safe_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int OPEN_CYCLES    = 500,
    parameter int ENTRY_TIMEOUT  = 2000,
    parameter int CNT_W          = 16
) (
    input logic           clk,
    input logic           reset,
    safe_sequencer_if.slave bus
);
    state_t           state_q, state_d;
    logic [1:0]       fail_q, fail_d;
    logic             clear_q, clear_d;
    logic             load_q, load_d;
    logic [2:0]       commit_q, commit_d;
    logic             t_load, t_zero;
    logic [CNT_W-1:0] t_val;
    logic             accept;

    assign accept = bus.key_valid & ~bus.star_valid
                  & (state_q inside {S_IDLE, S_ENTRY, S_CHG_NEW})
                  & (bus.input_length < MAX_PW_LEN);

    assign bus.digit_accept      = accept;
    assign bus.clear_input       = clear_q;
    assign bus.parallel_load     = load_q;
    assign bus.commit_length     = commit_q;
    assign bus.changing_password = (state_q == S_CHG_NEW);
    assign bus.door_open         = (state_q == S_OPEN);
    assign bus.alarm             = (state_q == S_LOCKOUT);
    assign bus.fail_count        = fail_q;
    assign bus.state             = state_q;

    safe_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (t_load),
        .value (t_val),
        .zero  (t_zero)
    );

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        clear_d  = load_q;
        load_d   = 1'b0;
        commit_d = commit_q;
        t_load   = 1'b0;
        t_val    = '0;
        if (state_q == S_LOCKOUT) begin
            if (t_zero) begin
                fail_d  = 2'd0;
                state_d = bus.is_on ? S_IDLE : S_OFF;
                clear_d = ~bus.is_on;
            end
        end else if (!bus.is_on) begin
            // fail_count survives power-off so a power cycle cannot dodge lockout
            state_d = S_OFF;
            if (state_q != S_OFF) clear_d = 1'b1;
        end else begin
            case (state_q)
                S_OFF: state_d = S_IDLE;
                S_IDLE: begin
                    if (bus.star_valid && bus.input_length != 3'd0) state_d = S_CHECK;
                    else if (accept) begin
                        state_d = S_ENTRY;
                        t_load  = 1'b1;
                        t_val   = CNT_W'(ENTRY_TIMEOUT);
                    end
                end
                S_ENTRY: begin
                    if (t_zero) begin
                        clear_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (bus.star_valid) state_d = S_CHECK;
                    else if (accept) begin
                        t_load = 1'b1;
                        t_val  = CNT_W'(ENTRY_TIMEOUT);
                    end
                end
                S_CHECK: begin
                    clear_d = 1'b1;
                    if (bus.correct) begin
                        fail_d  = 2'd0;
                        state_d = S_OPEN;
                        t_load  = 1'b1;
                        t_val   = CNT_W'(OPEN_CYCLES);
                    end else begin
                        fail_d  = (fail_q == 2'(MAX_FAILS)) ? fail_q : fail_q + 2'd1;
                        state_d = (fail_d == 2'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
                        t_load  = (fail_d == 2'(MAX_FAILS));
                        t_val   = CNT_W'(LOCKOUT_CYCLES);
                    end
                end
                S_OPEN: begin
                    if (t_zero || bus.star_valid) state_d = S_IDLE;
                    else if (bus.change_req) begin
                        state_d = S_CHG_NEW;
                        clear_d = 1'b1;
                    end
                end
                S_CHG_NEW: begin
                    if (bus.star_valid) begin
                        if (bus.input_length >= MIN_PW_LEN && bus.input_length <= MAX_PW_LEN) begin
                            load_d   = 1'b1;
                            commit_d = bus.input_length;
                            state_d  = S_IDLE;
                        end else clear_d = 1'b1;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_OFF;
            fail_q   <= 2'd0;
            clear_q  <= 1'b0;
            load_q   <= 1'b0;
            commit_q <= FACTORY_LEN;
        end else begin
            state_q  <= state_d;
            fail_q   <= fail_d;
            clear_q  <= clear_d;
            load_q   <= load_d;
            commit_q <= commit_d;
        end
    end
endmodule

// File: tb/tb_safe_sequencer.sv
// tb_safe_sequencer: randomized keypad sessions against a password/attempt model with an event scoreboard
module tb_safe_sequencer;
    import safe_pkg::*;
    localparam int MF = 3, LK = 30, OC = 20, ET = 40;
    localparam int EV_CHK = 1, EV_FAIL = 2, EV_OPEN = 3, EV_ALARM = 4, EV_LOAD = 5;

    typedef logic [3:0] dq_t[$];
    typedef struct {int k; int v;} ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    logic [3:0] key_digit = 4'd0;
    int n_checks = 0, n_err = 0;
    ev_t exp_q[$];
    dq_t in_q, ans_q, m_pw;
    int m_fails = 0;

    always #5 clk = ~clk;

    safe_sequencer_if bus();

    safe_sequencer #(
        .MAX_FAILS(MF), .LOCKOUT_CYCLES(LK), .OPEN_CYCLES(OC), .ENTRY_TIMEOUT(ET), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic bit same(input dq_t a, input dq_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // keypad datapath stand-in: input array, length counter, answer array, comparator
    always @(posedge clk) begin
        if (reset) begin
            in_q.delete();
            ans_q.delete();
            repeat (6) ans_q.push_back(4'd0);
        end else begin
            if (bus.parallel_load) ans_q = in_q;
            if (bus.clear_input) in_q.delete();
            else if (bus.digit_accept) in_q.push_back(key_digit);
        end
        bus.input_length <= 3'(in_q.size());
        bus.correct      <= same(in_q, ans_q);
    end

    task automatic emit(input int k, input int v);
        ev_t e;
        if (exp_q.size() == 0) chk("unexpected_event_kind", k, 0);
        else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.k);
            if (k == e.k) chk($sformatf("event%0d_value", k), v, e.v);
        end
    endtask

    int door_run = 0, alarm_run = 0;
    logic [1:0] fail_prev = 2'd0;
    logic chk_pend = 1'b0, load_pend = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_pend) emit(EV_CHK, int'(bus.clear_input));
            if (load_pend) emit(EV_LOAD, int'(bus.clear_input) * 8 + int'(bus.commit_length));
            if (bus.door_open) door_run++;
            else if (door_run > 0) begin emit(EV_OPEN, door_run); door_run = 0; end
            if (bus.alarm) alarm_run++;
            else if (alarm_run > 0) begin emit(EV_ALARM, alarm_run); alarm_run = 0; end
            if (bus.fail_count != fail_prev) emit(EV_FAIL, int'(bus.fail_count));
            fail_prev = bus.fail_count;
            chk_pend  = (bus.state == 3'(S_CHECK));
            load_pend = bus.parallel_load;
        end
    end

    task automatic push_ev(input int k, input int v);
        exp_q.push_back('{k, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] d, input bit with_star, input bit exp_acc);
        bus.key_valid = 1'b1;
        bus.star_valid = with_star;
        key_digit = d;
        #1;
        chk("digit_accept", int'(bus.digit_accept), int'(exp_acc));
        tick();
        bus.key_valid = 1'b0;
        bus.star_valid = 1'b0;
    endtask

    task automatic star();
        bus.star_valid = 1'b1;
        tick();
        bus.star_valid = 1'b0;
    endtask

    task automatic change();
        bus.change_req = 1'b1;
        tick();
        bus.change_req = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int budget, input string name);
        int n = 0;
        while (bus.state != 3'(s) && n < budget) begin tick(); n++; end
        chk(name, int'(bus.state), int'(s));
    endtask

    function automatic dq_t rand_code(input int lo, input int hi);
        dq_t c;
        int n = $urandom_range(hi, lo);
        repeat (n) c.push_back(4'($urandom_range(9, 0)));
        return c;
    endfunction

    function automatic dq_t wrong_code();
        dq_t c = rand_code(1, 6);
        if (same(c, m_pw)) c[0] = (c[0] == 4'd9) ? 4'd0 : c[0] + 4'd1;
        return c;
    endfunction

    // one attempt; expectations come from the password/attempt model only
    task automatic enter_code(input dq_t code, input bit combo, output bit opened);
        dq_t eff;
        int n = code.size();
        for (int i = 0; i < n; i++) begin
            bit last_combo = combo && (i == n - 1);
            if (i > 0) idle($urandom_range(2, 0));
            press(code[i], last_combo, !last_combo && i < 6);
            if (!last_combo && i < 6) eff.push_back(code[i]);
        end
        if (!combo) begin idle($urandom_range(2, 0)); star(); end
        push_ev(EV_CHK, 1);
        opened = same(eff, m_pw);
        if (opened) begin
            if (m_fails != 0) push_ev(EV_FAIL, 0);
            m_fails = 0;
        end else begin
            m_fails++;
            push_ev(EV_FAIL, m_fails);
            if (m_fails == MF) begin
                push_ev(EV_ALARM, LK + 1);
                push_ev(EV_FAIL, 0);
                m_fails = 0;
            end
        end
    endtask

    task automatic open_then_leave(input dq_t code, input bit combo);
        bit ok;
        enter_code(code, combo, ok);
        chk("attempt_opened", int'(ok), 1);
        push_ev(EV_OPEN, OC + 1);
        wait_state(S_IDLE, OC + 10, "open_expiry_state");
    endtask

    initial begin
        dq_t c, zeros, newpw;
        bit ok;
        int k;
        repeat (6) zeros.push_back(4'd0);
        m_pw = zeros;
        bus.is_on = 1'b0;
        bus.key_valid = 1'b0;
        bus.star_valid = 1'b0;
        bus.change_req = 1'b0;
        idle(3);
        chk("rst_state", int'(bus.state), int'(S_OFF));
        chk("rst_outputs", int'({bus.clear_input, bus.parallel_load, bus.changing_password,
                                 bus.door_open, bus.alarm, bus.fail_count}), 0);
        chk("rst_commit_length", int'(bus.commit_length), 6);
        reset = 1'b0;
        bus.is_on = 1'b1;
        mon_en = 1'b1;
        wait_state(S_IDLE, 4, "power_on_idle");

        // factory code opens, door held OPEN_CYCLES+1
        open_then_leave(zeros, 1'b0);
        chk("fail_after_open", int'(bus.fail_count), 0);

        // seventh digit dropped, early relock by star
        c = zeros; c.push_back(4'd0);
        enter_code(c, 1'b0, ok);
        chk("seven_digit_opened", int'(ok), 1);
        tick();
        k = $urandom_range(OC - 1, 0);
        idle(k);
        push_ev(EV_OPEN, k + 1);
        star();
        chk("relock_state", int'(bus.state), int'(S_IDLE));

        // three wrong attempts lead to lockout; everything ignored while locked
        for (int a = 0; a < MF; a++) begin
            enter_code(wrong_code(), 1'b0, ok);
            if (a < MF - 1) wait_state(S_IDLE, 4, "wrong_back_idle");
        end
        tick();
        chk("lockout_state", int'(bus.state), int'(S_LOCKOUT));
        for (int i = 0; i < 3; i++) press(4'($urandom_range(9, 0)), 1'b0, 1'b0);
        star();
        change();
        chk("lockout_holds", int'(bus.alarm), 1);
        wait_state(S_IDLE, LK + 10, "lockout_expiry_idle");
        chk("fail_after_lockout", int'(bus.fail_count), 0);

        // password change: short code rejected, five-digit code committed
        enter_code(zeros, 1'b0, ok);
        tick();
        k = $urandom_range(OC - 1, 0);
        idle(k);
        push_ev(EV_OPEN, k + 1);
        change();
        chk("chg_state", int'(bus.state), int'(S_CHG_NEW));
        chk("chg_flag", int'(bus.changing_password), 1);
        chk("chg_entry_clear", int'(bus.clear_input), 1);
        c = rand_code(3, 3);
        foreach (c[i]) press(c[i], 1'b0, 1'b1);
        star();
        chk("short_pw_state", int'(bus.state), int'(S_CHG_NEW));
        chk("short_pw_clear", int'(bus.clear_input), 1);
        chk("short_pw_no_load", int'(bus.parallel_load), 0);
        chk("short_pw_commit", int'(bus.commit_length), 6);
        idle(2);
        newpw = rand_code(5, 5);
        foreach (newpw[i]) press(newpw[i], 1'b0, 1'b1);
        star();
        push_ev(EV_LOAD, 8 + 5);
        m_pw = newpw;
        idle(2);
        chk("after_load_state", int'(bus.state), int'(S_IDLE));
        chk("after_load_commit", int'(bus.commit_length), 5);

        // new password with a key pressed together with the star
        c = newpw; c.push_back(4'($urandom_range(9, 0)));
        open_then_leave(c, 1'b1);

        // two fails survive a power cycle; third one locks, power-off during lockout
        for (int a = 0; a < 2; a++) begin
            enter_code(wrong_code(), 1'b0, ok);
            wait_state(S_IDLE, 4, "wrong_back_idle2");
        end
        bus.is_on = 1'b0;
        tick();
        chk("power_off_state", int'(bus.state), int'(S_OFF));
        chk("power_off_clear", int'(bus.clear_input), 1);
        idle(2);
        chk("power_off_clear_once", int'(bus.clear_input), 0);
        chk("fail_retained", int'(bus.fail_count), 2);
        bus.is_on = 1'b1;
        wait_state(S_IDLE, 4, "power_on_again");
        enter_code(wrong_code(), 1'b0, ok);
        idle(2);
        bus.is_on = 1'b0;
        idle(3);
        chk("lockout_ignores_power", int'(bus.state), int'(S_LOCKOUT));
        wait_state(S_OFF, LK + 10, "lockout_expiry_off");
        chk("fail_after_lockout2", int'(bus.fail_count), 0);
        bus.is_on = 1'b1;
        wait_state(S_IDLE, 4, "power_on_third");

        // idle entry timeout discards the partial input
        press(4'd7, 1'b0, 1'b1);
        press(4'd3, 1'b0, 1'b1);
        idle(ET);
        chk("entry_before_timeout", int'(bus.state), int'(S_ENTRY));
        tick();
        chk("entry_timeout_state", int'(bus.state), int'(S_IDLE));
        idle(2);
        chk("entry_timeout_length", int'(bus.input_length), 0);

        // reset in OPEN restores the factory password
        enter_code(m_pw, 1'b0, ok);
        tick();
        k = $urandom_range(OC - 1, 0);
        idle(k);
        push_ev(EV_OPEN, k + 1);
        reset = 1'b1;
        tick();
        chk("reset_door", int'(bus.door_open), 0);
        chk("reset_state_mid", int'(bus.state), int'(S_OFF));
        chk("reset_commit", int'(bus.commit_length), 6);
        chk("reset_no_load", int'(bus.parallel_load), 0);
        reset = 1'b0;
        m_pw = zeros;
        wait_state(S_IDLE, 4, "post_reset_idle");
        open_then_leave(zeros, 1'b0);

        idle(5);
        chk("events_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
